// File: rtl/rect_drawer_if.sv
// Command and pixel-port bundle between the object controller, the rectangle
// drawer and the VGA adapter write port.
interface rect_drawer_if #(
   parameter int X_W   = 8,
   parameter int Y_W   = 7,
   parameter int DIM_W = 5,
   parameter int C_W   = 3
);
   logic             start;
   logic [X_W-1:0]   x_in;
   logic [Y_W-1:0]   y_in;
   logic [DIM_W-1:0] width;
   logic [DIM_W-1:0] height;
   logic [C_W-1:0]   c_in;
   logic [1:0]       mode;
   logic             ready;
   logic [X_W-1:0]   x_out;
   logic [Y_W-1:0]   y_out;
   logic [C_W-1:0]   c_out;
   logic             plot;
   logic             busy;
   logic             done;

   modport master (
      output start, x_in, y_in, width, height, c_in, mode, ready,
      input  x_out, y_out, c_out, plot, busy, done
   );

   modport slave (
      input  start, x_in, y_in, width, height, c_in, mode, ready,
      output x_out, y_out, c_out, plot, busy, done
   );
endinterface

// File: rtl/rect_drawer.sv
// Rectangle rasteriser: fill, outline, erase and clear-screen commands, scanned
// row-major with screen-edge clipping and plot backpressure.
module rect_drawer #(
   parameter int X_W      = 8,
   parameter int Y_W      = 7,
   parameter int DIM_W    = 5,
   parameter int C_W      = 3,
   parameter int SCREEN_W = 160,
   parameter int SCREEN_H = 120
) (
   input logic          clk,
   input logic          reset,
   rect_drawer_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DRAW = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [X_W:0] SCR_W_C = (X_W+1)'(SCREEN_W);
   localparam logic [Y_W:0] SCR_H_C = (Y_W+1)'(SCREEN_H);

   state_t         state_r, state_nxt_s;
   logic [X_W-1:0] x0_r, w_r, cx_r, cx_nxt_s;
   logic [Y_W-1:0] y0_r, h_r, cy_r, cy_nxt_s;
   logic [C_W-1:0] col_r;
   logic [1:0]     mode_r;
   logic           latch_s;

   logic [X_W:0]   sum_x_s;
   logic [Y_W:0]   sum_y_s;
   logic           on_x_s, on_y_s, last_col_s, last_row_s, sel_s;
   logic           plot_s, adv_s, zero_s, clear_s;

   // Extra sum bit catches coordinates that wrap past the coordinate width.
   assign sum_x_s    = {1'b0, x0_r} + {1'b0, cx_r};
   assign sum_y_s    = {1'b0, y0_r} + {1'b0, cy_r};
   assign on_x_s     = !sum_x_s[X_W] && (sum_x_s < SCR_W_C);
   assign on_y_s     = !sum_y_s[Y_W] && (sum_y_s < SCR_H_C);
   assign last_col_s = (cx_r == (w_r - X_W'(1'b1)));
   assign last_row_s = (cy_r == (h_r - Y_W'(1'b1)));
   assign sel_s      = (mode_r != 2'b01) || (cx_r == '0) || last_col_s
                       || (cy_r == '0) || last_row_s;
   assign plot_s     = (state_r == DRAW) && on_x_s && on_y_s && sel_s;
   assign adv_s      = !plot_s || bus.ready;
   assign clear_s    = (bus.mode == 2'b11);
   assign zero_s     = ((bus.width == '0) || (bus.height == '0)) && !clear_s;

   // Next-state and scan-counter logic.
   always_comb begin
      state_nxt_s = state_r;
      cx_nxt_s    = cx_r;
      cy_nxt_s    = cy_r;
      latch_s     = 1'b0;
      case (state_r)
         IDLE: begin
            if (bus.start) begin
               latch_s     = 1'b1;
               cx_nxt_s    = '0;
               cy_nxt_s    = '0;
               state_nxt_s = zero_s ? DONE : DRAW;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         DRAW: begin
            if (adv_s) begin
               if (last_col_s) begin
                  cx_nxt_s = '0;
                  if (last_row_s) begin
                     state_nxt_s = DONE;
                  end else begin
                     cy_nxt_s = cy_r + Y_W'(1'b1);
                  end
               end else begin
                  cx_nxt_s = cx_r + X_W'(1'b1);
               end
            end else begin
               state_nxt_s = DRAW;
            end
         end
         DONE:    state_nxt_s = IDLE;
         default: state_nxt_s = IDLE;
      endcase
   end

   // State, counters and latched command operands.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r <= IDLE;
         cx_r    <= '0;
         cy_r    <= '0;
         x0_r    <= '0;
         y0_r    <= '0;
         w_r     <= '0;
         h_r     <= '0;
         col_r   <= '0;
         mode_r  <= 2'b00;
      end else begin
         state_r <= state_nxt_s;
         cx_r    <= cx_nxt_s;
         cy_r    <= cy_nxt_s;
         if (latch_s) begin
            x0_r   <= clear_s ? '0 : bus.x_in;
            y0_r   <= clear_s ? '0 : bus.y_in;
            w_r    <= clear_s ? X_W'(SCREEN_W) : X_W'(bus.width);
            h_r    <= clear_s ? Y_W'(SCREEN_H) : Y_W'(bus.height);
            col_r  <= (bus.mode == 2'b10) ? '0 : bus.c_in;
            mode_r <= bus.mode;
         end
      end
   end

   assign bus.x_out = sum_x_s[X_W-1:0];
   assign bus.y_out = sum_y_s[Y_W-1:0];
   assign bus.c_out = col_r;
   assign bus.plot  = plot_s;
   assign bus.busy  = (state_r != IDLE);
   assign bus.done  = (state_r == DONE);
endmodule

// File: tb/tb_rect_drawer.sv
// Directed bench for rect_drawer: a table of whole commands plus hand-timed
// sequences for backpressure, start-while-busy and reset mid-draw.
module tb_rect_drawer;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   rect_drawer_if #(.X_W(8), .Y_W(7), .DIM_W(5), .C_W(3)) bus();

   rect_drawer #(.X_W(8), .Y_W(7), .DIM_W(5), .C_W(3),
                 .SCREEN_W(160), .SCREEN_H(120))
      dut (.clk(clk), .reset(reset), .bus(bus));

   typedef struct {
      logic [7:0] x;
      logic [6:0] y;
      logic [4:0] w;
      logic [4:0] h;
      logic [2:0] c;
      logic [1:0] m;
      logic [2:0] ec;
      int np, dn, fx, fy, lx, ly, xs, ys;
   } vec_t;

   vec_t vecs[12];
   int n_vec = 0;
   int n_err = 0;
   int r_np, r_done, r_fx, r_fy, r_lx, r_ly, r_xs, r_ys, r_badc, r_off, r_bgap, r_busy_after;

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic run_cmd(input logic [7:0] x, input logic [6:0] y, input logic [4:0] w,
                          input logic [4:0] h, input logic [2:0] c, input logic [1:0] m,
                          input logic [2:0] ec);
      bus.x_in = x; bus.y_in = y; bus.width = w; bus.height = h;
      bus.c_in = c; bus.mode = m; bus.ready = 1'b1; bus.start = 1'b1;
      r_np = 0; r_done = -1; r_fx = -1; r_fy = -1; r_lx = -1; r_ly = -1;
      r_xs = 0; r_ys = 0; r_badc = 0; r_off = 0; r_bgap = 0;
      @(posedge clk); #1;
      bus.start = 1'b0;
      for (int cyc = 1; cyc <= 20000; cyc++) begin
         if (bus.plot) begin
            if (r_np == 0) begin
               r_fx = int'(bus.x_out);
               r_fy = int'(bus.y_out);
            end
            r_lx = int'(bus.x_out);
            r_ly = int'(bus.y_out);
            r_np++;
            r_xs += int'(bus.x_out);
            r_ys += int'(bus.y_out);
            if (bus.c_out !== ec) r_badc++;
            if (bus.x_out >= 8'd160 || bus.y_out >= 7'd120) r_off++;
         end
         if (!bus.busy) r_bgap++;
         if (bus.done) begin
            r_done = cyc;
            break;
         end
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      r_busy_after = int'(bus.busy);
   endtask

   initial begin
      int dpulses;
      // x, y, w, h, c, mode, expected colour, plots, done cycle, first x/y, last x/y, x sum, y sum
      vecs[0]  = '{8'd10,  7'd20,  5'd3,  5'd2, 3'd5, 2'd0, 3'd5,     6,     7,  10,  20,  12,  21,      66,     123};
      vecs[1]  = '{8'd0,   7'd0,   5'd4,  5'd3, 3'd3, 2'd1, 3'd3,    10,    13,   0,   0,   3,   2,      15,      10};
      vecs[2]  = '{8'd5,   7'd5,   5'd2,  5'd2, 3'd7, 2'd2, 3'd0,     4,     5,   5,   5,   6,   6,      22,      22};
      vecs[3]  = '{8'd158, 7'd118, 5'd4,  5'd4, 3'd1, 2'd0, 3'd1,     4,    17, 158, 118, 159, 119,     634,     474};
      vecs[4]  = '{8'd3,   7'd3,   5'd0,  5'd5, 3'd1, 2'd0, 3'd1,     0,     1,  -1,  -1,  -1,  -1,       0,       0};
      vecs[5]  = '{8'd7,   7'd9,   5'd1,  5'd1, 3'd6, 2'd1, 3'd6,     1,     2,   7,   9,   7,   9,       7,       9};
      vecs[6]  = '{8'd2,   7'd4,   5'd1,  5'd3, 3'd4, 2'd1, 3'd4,     3,     4,   2,   4,   2,   6,       6,      15};
      vecs[7]  = '{8'd0,   7'd100, 5'd5,  5'd1, 3'd2, 2'd1, 3'd2,     5,     6,   0, 100,   4, 100,      10,     500};
      vecs[8]  = '{8'd50,  7'd50,  5'd3,  5'd3, 3'd2, 2'd3, 3'd2, 19200, 19201,   0,   0, 159, 119, 1526400, 1142400};
      vecs[9]  = '{8'd1,   7'd1,   5'd4,  5'd0, 3'd1, 2'd2, 3'd0,     0,     1,  -1,  -1,  -1,  -1,       0,       0};
      vecs[10] = '{8'd250, 7'd0,   5'd10, 5'd1, 3'd1, 2'd0, 3'd1,     0,    11,  -1,  -1,  -1,  -1,       0,       0};
      vecs[11] = '{8'd0,   7'd126, 5'd1,  5'd4, 3'd1, 2'd0, 3'd1,     0,     5,  -1,  -1,  -1,  -1,       0,       0};

      reset = 1'b0;
      bus.start = 1'b0; bus.x_in = 8'd0; bus.y_in = 7'd0; bus.width = 5'd0;
      bus.height = 5'd0; bus.c_in = 3'd0; bus.mode = 2'd0; bus.ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset x_out", int'(bus.x_out), 0);
      chk("reset y_out", int'(bus.y_out), 0);
      chk("reset c_out", int'(bus.c_out), 0);
      chk("reset plot",  int'(bus.plot),  0);
      chk("reset busy",  int'(bus.busy),  0);
      chk("reset done",  int'(bus.done),  0);
      reset = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 12; i++) begin
         run_cmd(vecs[i].x, vecs[i].y, vecs[i].w, vecs[i].h, vecs[i].c, vecs[i].m, vecs[i].ec);
         chk($sformatf("v%0d plots", i),      r_np,   vecs[i].np);
         chk($sformatf("v%0d done cycle", i), r_done, vecs[i].dn);
         chk($sformatf("v%0d first x", i),    r_fx,   vecs[i].fx);
         chk($sformatf("v%0d first y", i),    r_fy,   vecs[i].fy);
         chk($sformatf("v%0d last x", i),     r_lx,   vecs[i].lx);
         chk($sformatf("v%0d last y", i),     r_ly,   vecs[i].ly);
         chk($sformatf("v%0d x sum", i),      r_xs,   vecs[i].xs);
         chk($sformatf("v%0d y sum", i),      r_ys,   vecs[i].ys);
         chk($sformatf("v%0d bad colour", i), r_badc, 0);
         chk($sformatf("v%0d off-screen", i), r_off,  0);
         chk($sformatf("v%0d busy gap", i),   r_bgap, 0);
         chk($sformatf("v%0d busy after", i), r_busy_after, 0);
      end

      // Backpressure: 2x1 fill, ready low during the first three pixel cycles.
      bus.x_in = 8'd30; bus.y_in = 7'd40; bus.width = 5'd2; bus.height = 5'd1;
      bus.c_in = 3'd1; bus.mode = 2'd0; bus.ready = 1'b0; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      chk("bp c1 plot", int'(bus.plot), 1);
      chk("bp c1 x", int'(bus.x_out), 30);
      for (int k = 2; k <= 4; k++) begin
         @(posedge clk); #1;
         chk($sformatf("bp c%0d plot", k), int'(bus.plot), 1);
         chk($sformatf("bp c%0d x", k), int'(bus.x_out), 30);
         chk($sformatf("bp c%0d y", k), int'(bus.y_out), 40);
         if (k == 4) bus.ready = 1'b1;
      end
      @(posedge clk); #1;
      chk("bp c5 plot", int'(bus.plot), 1);
      chk("bp c5 x", int'(bus.x_out), 31);
      chk("bp c5 done", int'(bus.done), 0);
      @(posedge clk); #1;
      chk("bp c6 done", int'(bus.done), 1);
      chk("bp c6 plot", int'(bus.plot), 0);
      @(posedge clk); #1;
      chk("bp c7 busy", int'(bus.busy), 0);

      // start pulsed while drawing must not disturb the running command.
      bus.x_in = 8'd0; bus.y_in = 7'd0; bus.width = 5'd3; bus.height = 5'd1;
      bus.c_in = 3'd4; bus.mode = 2'd0; bus.ready = 1'b1; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      @(posedge clk); #1;
      bus.start = 1'b1; bus.mode = 2'd3; bus.width = 5'd9; bus.c_in = 3'd6;
      @(posedge clk); #1;
      bus.start = 1'b0;
      chk("sd c3 plot", int'(bus.plot), 1);
      chk("sd c3 x", int'(bus.x_out), 2);
      chk("sd c3 colour", int'(bus.c_out), 4);
      @(posedge clk); #1;
      chk("sd c4 done", int'(bus.done), 1);
      @(posedge clk); #1;
      chk("sd c5 busy", int'(bus.busy), 0);

      // Reset mid-draw abandons the rectangle without a done pulse.
      bus.x_in = 8'd20; bus.y_in = 7'd30; bus.width = 5'd4; bus.height = 5'd4;
      bus.c_in = 3'd3; bus.mode = 2'd0; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      chk("rst x_out", int'(bus.x_out), 0);
      chk("rst y_out", int'(bus.y_out), 0);
      chk("rst c_out", int'(bus.c_out), 0);
      chk("rst plot",  int'(bus.plot),  0);
      chk("rst busy",  int'(bus.busy),  0);
      chk("rst done",  int'(bus.done),  0);
      reset = 1'b1;
      dpulses = 0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk); #1;
         if (bus.done || bus.busy) dpulses++;
      end
      chk("rst no activity", dpulses, 0);
      run_cmd(8'd10, 7'd20, 5'd3, 5'd2, 3'd5, 2'd0, 3'd5);
      chk("post-rst plots", r_np, 6);
      chk("post-rst done cycle", r_done, 7);
      chk("post-rst first x", r_fx, 10);
      chk("post-rst last y", r_ly, 21);
      chk("post-rst bad colour", r_badc, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/rect_drawer.md
# rect_drawer

Parametrised rectangle rasteriser. It supersedes the fixed-size single-mode drawer and adds a start/done handshake, fill, outline, erase and clear-screen modes, screen-edge clipping and plot backpressure. It sits between the game-object controller (which issues draw commands) and the VGA adapter's pixel write port. It emits one pixel coordinate per accepted cycle, in row-major order.

## Interface
Parameters:
- X_W, 8, x coordinate width
- Y_W, 7, y coordinate width
- DIM_W, 5, width/height operand width
- C_W, 3, colour width
- SCREEN_W, 160, visible columns; x >= SCREEN_W is off-screen
- SCREEN_H, 120, visible rows; y >= SCREEN_H is off-screen

Ports:
- clk  in  1  circuit clock
- reset  in  1  one clock; reset is synchronous and active-low
- start  in  1  command strobe; sampled only in IDLE
- x_in  in  X_W  top-left x
- y_in  in  Y_W  top-left y
- width  in  DIM_W  rectangle width in pixels
- height  in  DIM_W  rectangle height in pixels
- c_in  in  C_W  draw colour
- mode  in  2  00 fill, 01 outline, 10 erase, 11 clear screen
- ready  in  1  VGA port accepts the current pixel
- x_out  out  X_W  current pixel x
- y_out  out  Y_W  current pixel y
- c_out  out  C_W  current pixel colour
- plot  out  1  pixel valid (write enable)
- busy  out  1  command in progress
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, DRAW, DONE.
- IDLE → DRAW when start=1. On that edge, latch x0, y0, w, h, colour and mode; clear counters cx and cy. cx is X_W wide and cy is Y_W wide.
- Zero-area command (w=0 or h=0, not mode 11): IDLE → DONE directly. No plot is issued.
- Mode 11 ignores x_in, y_in, width and height. It uses x0=0, y0=0, w=SCREEN_W, h=SCREEN_H.
- Mode 10 forces the latched colour to 0.
- Scan order: cx runs 0..w-1 within a row, then cx returns to 0 and cy increments. When the last pixel (cx=w-1, cy=h-1) advances, go to DONE.
- Pixel address: x_out = x0+cx, y_out = y0+cy. Both sums are computed one bit wider than the coordinate.
- A pixel is on-screen only if its sum has no carry and it is below SCREEN_W / SCREEN_H.
- Selected pixels:
  - modes 00/10/11: every pixel;
  - mode 01: only cx=0, cx=w-1, cy=0 or cy=h-1.
- plot = DRAW and on-screen and selected.
- Advance condition: !plot or ready.
  - Pixels with plot low (clipped or interior) advance one per cycle without waiting for ready.
  - While plot=1 and ready=0, all of x_out, y_out, c_out and plot hold stable.
- DONE lasts one cycle: done=1, busy=1, plot=0. Then return to IDLE.
- start is ignored in DRAW and DONE. start held in DONE is not re-sampled until IDLE.
- Reset (reset=0 at an edge) takes effect at that edge from any state, including mid-DRAW. The result is IDLE with counters cleared. Any partial rectangle is abandoned and done is not pulsed.

## Timing
- Reset values: x_out=0, y_out=0, c_out=0, plot=0, busy=0, done=0.
- All outputs are registered or decoded from registered state; there is no combinational path from inputs to outputs.
- start sampled at edge N → busy=1 and the first pixel is presented in cycle N+1.
- With ready held high, pixel k (row-major, k=0..w·h-1) is presented in cycle N+1+k. done=1 in cycle N+1+w·h. busy=0 from cycle N+2+w·h.
- Each ready-low cycle while plot=1 adds exactly one cycle of latency.
- Zero-area command: done=1 in cycle N+1, busy=0 from N+2.
- Outline 1×1: a single plot. Outline with w=1 or h=1 plots every pixel.

## Test plan
- Fill, x_in=10, y_in=20, w=3, h=2, c=5, ready=1:
  - plot high for 6 consecutive cycles at (10,20),(11,20),(12,20),(10,21),(11,21),(12,21) with c_out=5;
  - done pulse on the 7th cycle after start;
  - busy low on the 8th.
- Outline, (0,0), w=4, h=3: plot on 10 of 12 cycles; (1,1) and (2,1) are skipped with plot=0. Erase, (5,5), 2×2, c_in=7: four plots with c_out=0.
- Clipping, x_in=158, y_in=118, w=4, h=4: only (158,118),(159,118),(158,119),(159,119) are plotted. Total DRAW time is still 16 cycles.
- Backpressure: fill 2×1 with ready=0 for 3 cycles on the first pixel. Outputs hold (x,y) stable, the second pixel appears after ready rises, and done arrives 3 cycles later than the unstalled case.
- Clear screen, mode 11, c=2: exactly 19200 plots covering (0,0)..(159,119); no plot outside the screen.
- Robustness:
  - start with w=0: done the next cycle, no plot;
  - start pulsed during DRAW: ignored;
  - reset=0 mid-DRAW: all outputs 0 at the next edge, no done, and a new command afterwards behaves normally.
